// File: rtl/psum_acc_buffer.sv
// Partial-sum accumulation buffer: sums per-column psum beats over all row tiles,
// then drains the completed output feature map over a valid/ready handshake.
module psum_acc_buffer #(
    parameter int unsigned PE_SIZE        = 14,
    parameter int unsigned WEIGHT_ROW_NUM = 294,
    parameter int unsigned WEIGHT_COL_NUM = 70,
    parameter int unsigned PSUM_WIDTH     = 32,
    parameter int unsigned ACC_WIDTH      = 40,
    localparam int unsigned ROW_TILES     = WEIGHT_ROW_NUM / PE_SIZE,
    localparam int unsigned TILE_W        = (ROW_TILES > 1) ? $clog2(ROW_TILES) : 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            psum_en_i,
    input  logic [PE_SIZE*PSUM_WIDTH-1:0]   psum_i,
    output logic                            psum_ready_o,
    output logic                            ofmap_valid_o,
    output logic [PE_SIZE*ACC_WIDTH-1:0]    ofmap_data_o,
    input  logic                            ofmap_ready_i,
    output logic [TILE_W-1:0]               tile_idx_o,
    output logic                            done_o,
    output logic                            drop_err_o
);

    localparam int unsigned ADDR_W  = (WEIGHT_COL_NUM > 1) ? $clog2(WEIGHT_COL_NUM) : 1;
    localparam int unsigned ENTRY_W = PE_SIZE * ACC_WIDTH;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WEIGHT_COL_NUM - 1);
    localparam logic [TILE_W-1:0] LAST_TILE = TILE_W'(ROW_TILES - 1);

    typedef enum logic [0:0] {
        ST_ACCUM = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
    logic [TILE_W-1:0]   tile_q, tile_d;
    logic                ready_d, valid_d, done_d, drop_d;
    logic [ENTRY_W-1:0]  data_d;
    logic                wr_en_c;
    logic [ENTRY_W-1:0]  sum_c;

    logic [ENTRY_W-1:0]  buf_q [WEIGHT_COL_NUM];

    // Per-lane sign extension and accumulate; tile 0 overwrites stale contents.
    for (genvar k = 0; k < PE_SIZE; k++) begin : g_lane
        logic signed [PSUM_WIDTH-1:0] psum_lane;
        logic signed [ACC_WIDTH-1:0]  psum_ext;
        logic signed [ACC_WIDTH-1:0]  base;

        assign psum_lane = psum_i[k*PSUM_WIDTH +: PSUM_WIDTH];
        assign psum_ext  = ACC_WIDTH'(psum_lane);
        assign base      = (tile_q == '0) ? '0 : buf_q[wr_addr_q][k*ACC_WIDTH +: ACC_WIDTH];
        assign sum_c[k*ACC_WIDTH +: ACC_WIDTH] = base + psum_ext;
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d   = state_q;
        wr_addr_d = wr_addr_q;
        rd_addr_d = rd_addr_q;
        tile_d    = tile_q;
        ready_d   = psum_ready_o;
        valid_d   = ofmap_valid_o;
        data_d    = ofmap_data_o;
        done_d    = 1'b0;
        drop_d    = drop_err_o | (psum_en_i & ~psum_ready_o);
        wr_en_c   = 1'b0;

        case (state_q)
            ST_ACCUM: begin
                if (psum_en_i && psum_ready_o) begin
                    wr_en_c = 1'b1;
                    if (wr_addr_q == LAST_ADDR) begin
                        wr_addr_d = '0;
                        if (tile_q == LAST_TILE) begin
                            tile_d  = '0;
                            state_d = ST_DRAIN;
                            ready_d = 1'b0;
                            valid_d = 1'b1;
                            // Entry 0 is only being written now when the buffer is one deep.
                            data_d  = (wr_addr_q == '0) ? sum_c : buf_q[0];
                        end else begin
                            tile_d = tile_q + TILE_W'(1);
                        end
                    end else begin
                        wr_addr_d = wr_addr_q + ADDR_W'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if (ofmap_ready_i) begin
                    if (rd_addr_q == LAST_ADDR) begin
                        rd_addr_d = '0;
                        state_d   = ST_ACCUM;
                        ready_d   = 1'b1;
                        valid_d   = 1'b0;
                        data_d    = '0;
                        done_d    = 1'b1;
                    end else begin
                        rd_addr_d = rd_addr_q + ADDR_W'(1);
                        data_d    = buf_q[rd_addr_q + ADDR_W'(1)];
                    end
                end
            end
            default: state_d = ST_ACCUM;
        endcase
    end

    // Control and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_ACCUM;
            wr_addr_q     <= '0;
            rd_addr_q     <= '0;
            tile_q        <= '0;
            psum_ready_o  <= 1'b1;
            ofmap_valid_o <= 1'b0;
            ofmap_data_o  <= '0;
            done_o        <= 1'b0;
            drop_err_o    <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_addr_q     <= wr_addr_d;
            rd_addr_q     <= rd_addr_d;
            tile_q        <= tile_d;
            psum_ready_o  <= ready_d;
            ofmap_valid_o <= valid_d;
            ofmap_data_o  <= data_d;
            done_o        <= done_d;
            drop_err_o    <= drop_d;
        end
    end

    // Buffer storage is not reset; tile 0 overwrites every entry.
    always_ff @(posedge clk) begin
        if (rst_n && wr_en_c) begin
            buf_q[wr_addr_q] <= sum_c;
        end
    end

    assign tile_idx_o = tile_q;

endmodule

// File: tb/tb_psum_acc_buffer.sv
// Directed bench for psum_acc_buffer with a model-fed scoreboard; a second instance
// with an 8-bit accumulator shares the stimulus to exercise accumulator wrap.
module tb_psum_acc_buffer;

    localparam int unsigned PE = 2, ROWS = 6, COLS = 3, PW = 8, AWA = 10, AWB = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             psum_en;
    logic [PE*PW-1:0] psum_i;
    logic             ofmap_ready;

    logic              ready_a, valid_a, done_a, drop_a;
    logic [PE*AWA-1:0] data_a;
    logic [1:0]        tile_a;
    logic              ready_b, valid_b, done_b, drop_b;
    logic [PE*AWB-1:0] data_b;
    logic [1:0]        tile_b;

    psum_acc_buffer #(.PE_SIZE(PE), .WEIGHT_ROW_NUM(ROWS), .WEIGHT_COL_NUM(COLS),
                      .PSUM_WIDTH(PW), .ACC_WIDTH(AWA)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .psum_en_i(psum_en), .psum_i(psum_i),
        .psum_ready_o(ready_a), .ofmap_valid_o(valid_a), .ofmap_data_o(data_a),
        .ofmap_ready_i(ofmap_ready), .tile_idx_o(tile_a), .done_o(done_a), .drop_err_o(drop_a));

    psum_acc_buffer #(.PE_SIZE(PE), .WEIGHT_ROW_NUM(ROWS), .WEIGHT_COL_NUM(COLS),
                      .PSUM_WIDTH(PW), .ACC_WIDTH(AWB)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .psum_en_i(psum_en), .psum_i(psum_i),
        .psum_ready_o(ready_b), .ofmap_valid_o(valid_b), .ofmap_data_o(data_b),
        .ofmap_ready_i(ofmap_ready), .tile_idx_o(tile_b), .done_o(done_b), .drop_err_o(drop_b));

    always #5 clk = ~clk;

    int passes = 0;
    int total  = 0;

    // Reference model state
    int                 m_wr = 0, m_tile = 0;
    logic signed [AWA-1:0] acc_a [COLS][PE];
    logic signed [AWB-1:0] acc_b [COLS][PE];
    logic [PE*AWA-1:0]  exp_a [$];
    logic [PE*AWB-1:0]  exp_b [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic reset_dut();
        rst_n   = 1'b0;
        psum_en = 1'b0;
        @(negedge clk);
        rst_n  = 1'b1;
        m_wr   = 0;
        m_tile = 0;
        exp_a.delete();
        exp_b.delete();
    endtask

    // Drive one beat at a negedge and update the model as an accepted beat.
    task automatic beat(input int l0, input int l1);
        logic signed [PW-1:0] v [PE];
        chk("beat_ready", 64'(ready_a), 64'(1));
        chk("beat_tile", 64'(tile_a), 64'(m_tile));
        psum_en = 1'b1;
        psum_i  = {l1[PW-1:0], l0[PW-1:0]};
        v[0] = l0[PW-1:0];
        v[1] = l1[PW-1:0];
        for (int k = 0; k < PE; k++) begin
            if (m_tile == 0) begin
                acc_a[m_wr][k] = AWA'(v[k]);
                acc_b[m_wr][k] = AWB'(v[k]);
            end else begin
                acc_a[m_wr][k] = acc_a[m_wr][k] + AWA'(v[k]);
                acc_b[m_wr][k] = acc_b[m_wr][k] + AWB'(v[k]);
            end
        end
        if (m_wr == COLS - 1) begin
            m_wr = 0;
            if (m_tile == ROWS / PE - 1) begin
                m_tile = 0;
                for (int c = 0; c < COLS; c++) begin
                    exp_a.push_back({acc_a[c][1], acc_a[c][0]});
                    exp_b.push_back({acc_b[c][1], acc_b[c][0]});
                end
            end else begin
                m_tile++;
            end
        end else begin
            m_wr++;
        end
        @(negedge clk);
        psum_en = 1'b0;
    endtask

    // Drain all entries, optionally stalling for a number of cycles once valid is seen.
    task automatic drain(input int stall);
        int got = 0;
        int cyc = 0;
        int st  = stall;
        logic [PE*AWA-1:0] ea;
        logic [PE*AWB-1:0] eb;
        while (got < COLS && cyc < 60) begin
            ofmap_ready = 1'b0;
            if (valid_a) begin
                if (exp_a.size() == 0 || exp_b.size() == 0) begin
                    chk("queue_empty", 64'(exp_a.size()), 64'(COLS - got));
                    got = COLS;
                end else if (st > 0) begin
                    chk("stall_data", 64'(data_a), 64'(exp_a[0]));
                    st--;
                end else begin
                    ofmap_ready = 1'b1;
                    ea = exp_a.pop_front();
                    eb = exp_b.pop_front();
                    chk("drain_data_a", 64'(data_a), 64'(ea));
                    chk("drain_data_b", 64'(data_b), 64'(eb));
                    got++;
                end
            end else if (st != stall) begin
                chk("valid_dropped_in_stall", 64'(valid_a), 64'(1));
            end
            @(negedge clk);
            cyc++;
        end
        ofmap_ready = 1'b0;
        if (got < COLS) chk("drain_timeout", 64'(got), 64'(COLS));
        chk("done_pulse", 64'(done_a), 64'(1));
        chk("ready_after_drain", 64'(ready_a), 64'(1));
        chk("valid_after_drain", 64'(valid_a), 64'(0));
        chk("tile_after_drain", 64'(tile_a), 64'(0));
        @(negedge clk);
        chk("done_one_cycle", 64'(done_a), 64'(0));
        chk("queue_left", 64'(exp_a.size()), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n       = 1'b0;
        psum_en     = 1'b0;
        psum_i      = '0;
        ofmap_ready = 1'b0;
        @(negedge clk);
        reset_dut();
        chk("rst_ready", 64'(ready_a), 64'(1));
        chk("rst_valid", 64'(valid_a), 64'(0));
        chk("rst_data", 64'(data_a), 64'(0));
        chk("rst_done", 64'(done_a), 64'(0));
        chk("rst_drop", 64'(drop_a), 64'(0));
        chk("rst_tile", 64'(tile_a), 64'(0));

        // Basic: constant beats
        for (int i = 0; i < 9; i++) beat(1, 2);
        chk("basic_ready_low", 64'(ready_a), 64'(0));
        chk("basic_valid_first", 64'(valid_a), 64'(1));
        chk("basic_entry0", 64'(data_a), 64'({10'sd6, 10'sd3}));
        drain(0);

        // Column addressing: lane0 = 10*tile + col
        for (int t = 0; t < 3; t++)
            for (int c = 0; c < 3; c++) beat(10 * t + c, c);
        chk("col_entry0", 64'(data_a), 64'({10'sd0, 10'sd30}));
        drain(0);

        // Backpressure
        for (int t = 0; t < 3; t++)
            for (int c = 0; c < 3; c++) beat(t + c, 2 * c + 1);
        drain(5);

        // Gaps, then beats during DRAIN are dropped
        for (int i = 0; i < 9; i++) begin
            beat(1, 2);
            @(negedge clk);
        end
        chk("gap_drop_clear", 64'(drop_a), 64'(0));
        psum_en = 1'b1;
        psum_i  = 16'h7F7F;
        @(negedge clk);
        chk("gap_drop_set", 64'(drop_a), 64'(1));
        chk("gap_ready_low", 64'(ready_a), 64'(0));
        @(negedge clk);
        psum_en = 1'b0;
        drain(0);
        chk("gap_drop_sticky", 64'(drop_a), 64'(1));

        // Signed: -1 each beat
        for (int i = 0; i < 9; i++) beat(-1, 3);
        chk("neg_entry0", 64'(data_a), 64'({10'sd9, 10'h3FD}));
        drain(0);

        // Wrap in the 8-bit accumulator instance
        for (int t = 0; t < 3; t++)
            for (int c = 0; c < 3; c++) beat((t == 0) ? 127 : ((t == 1) ? 1 : 0), -128);
        chk("wrap_b_entry0", 64'(data_b[7:0]), 64'(8'h80));
        drain(0);

        // Reset mid-run
        for (int i = 0; i < 4; i++) beat(5, 7);
        chk("mid_tile_before", 64'(tile_a), 64'(1));
        reset_dut();
        chk("mid_tile_after", 64'(tile_a), 64'(0));
        chk("mid_drop_after", 64'(drop_a), 64'(0));
        chk("mid_ready_after", 64'(ready_a), 64'(1));
        for (int i = 0; i < 9; i++) beat(1, 0);
        chk("mid_entry0", 64'(data_a), 64'({10'sd0, 10'sd3}));
        drain(0);
        chk("mid_drop_end", 64'(drop_a), 64'(0));

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule

// File: doc/psum_acc_buffer.md
Name: psum_acc_buffer

Overview:
- Downstream of the systolic PE array and consumes the same psum_en_i stream that drives the accumulation counter.
- Sums per-column partial sums over all row tiles of a weight matrix.
- Holds results in a WEIGHT_COL_NUM-deep register buffer, PE_SIZE lanes per entry.
- After the final tile, drains the completed output feature map to the next stage over a valid/ready handshake, one entry per handshake.

Parameters:
- PE_SIZE, 14, lanes per psum beat (PE array width).
- WEIGHT_ROW_NUM, 294, weight rows; ROW_TILES = WEIGHT_ROW_NUM/PE_SIZE (integer division, must divide exactly).
- WEIGHT_COL_NUM, 70, psum beats per tile = buffer depth.
- PSUM_WIDTH, 32, signed width of one input lane.
- ACC_WIDTH, 40, signed width of one accumulated lane (ACC_WIDTH >= PSUM_WIDTH).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- psum_en_i  in  1  psum beat present on psum_i.
- psum_i  in  PE_SIZE*PSUM_WIDTH  signed psums; lane k at bits [k*PSUM_WIDTH +: PSUM_WIDTH].
- psum_ready_o  out  1  high while in ACCUM; a beat is accepted iff psum_en_i && psum_ready_o.
- ofmap_valid_o  out  1  ofmap_data_o holds a completed entry.
- ofmap_data_o  out  PE_SIZE*ACC_WIDTH  accumulated entry, same lane packing.
- ofmap_ready_i  in  1  consumer accepts the entry when high together with ofmap_valid_o.
- tile_idx_o  out  $clog2(ROW_TILES)  current row tile being accumulated.
- done_o  out  1  one-cycle pulse after the last entry is drained.
- drop_err_o  out  1  sticky: a psum beat arrived while not ready.

Behaviour:

Reset (synchronous, rst_n low at a clk edge):
- State ACCUM; wr_addr=0, tile=0, rd_addr=0.
- psum_ready_o=1, ofmap_valid_o=0, ofmap_data_o=0, done_o=0, drop_err_o=0.
- Buffer contents need not be cleared; tile 0 overwrites them.
- Reset mid-operation aborts everything, discards the partial sums, and returns to this state.

State ACCUM:
- On each accepted beat, entry[wr_addr] is updated next edge:
  - tile==0: overwrite with sign-extended psum per lane.
  - tile>0: entry + sign-extended psum per lane, two's-complement wrap at ACC_WIDTH, no saturation.
- wr_addr increments. At WEIGHT_COL_NUM-1 it wraps to 0 and tile increments.
- When the beat at wr_addr=WEIGHT_COL_NUM-1, tile=ROW_TILES-1 is accepted:
  - next state DRAIN; tile and wr_addr return to 0.
  - psum_ready_o drops the following cycle.
- Cycles without psum_en_i hold all state; gaps have no effect on results.

State DRAIN:
- ofmap_valid_o=1 and ofmap_data_o=entry[rd_addr], registered.
- First entry is valid in the cycle after the last psum is written.
- On handshake:
  - rd_addr increments and the next entry appears the following cycle.
  - Back-to-back handshakes give one entry per cycle.
- While ofmap_ready_i is low, valid and data are held stable.
- On the handshake at rd_addr=WEIGHT_COL_NUM-1:
  - next cycle: state ACCUM, rd_addr=0, ofmap_valid_o=0, psum_ready_o=1, done_o=1 for exactly one cycle.
- psum_en_i high during DRAIN: the beat is dropped, drop_err_o is set and stays set until reset, and buffer and counters are untouched.

Other rules:
- psum_en_i on the same cycle psum_ready_o rises is accepted as tile 0 beat 0.
- tile_idx_o mirrors tile (0 in DRAIN).

Test Plan (PE_SIZE=2, WEIGHT_ROW_NUM=6, WEIGHT_COL_NUM=3, PSUM_WIDTH=8, ACC_WIDTH=10 unless noted):
- Basic: 9 consecutive beats, lane0=1, lane1=2, ofmap_ready_i=1.
  - -> psum_ready_o low from the cycle after beat 9; 3 entries drained on consecutive cycles, each lane0=3, lane1=6.
  - -> done_o pulses once, then psum_ready_o=1.
- Column addressing: beat values lane0 = 10*tile + col.
  - -> entries lane0 = {30, 33, 36} in rd order 0, 1, 2.
- Backpressure: ofmap_ready_i low for 5 cycles after valid rises, then high.
  - -> valid held high and data frozen at entry 0 for all 5 cycles; afterwards all 3 entries delivered in order, none lost or repeated.
- Gaps and drop: psum_en_i toggles 1,0,1,0 through 9 accepted beats, then 2 beats driven during DRAIN.
  - -> results equal the Basic case; drop_err_o=1 from the cycle after the first dropped beat; drained data unchanged.
- Signed/wrap: lane0=-1 every beat -> -3 (10'h3FD).
  - Separate run, ACC_WIDTH=8, lane0=127 at tile 0 and 1 at tile 1, 0 at tile 2 -> -128.
- Reset mid-run: rst_n low for one edge after 4 beats, then 9 beats of lane0=1.
  - -> tile_idx_o=0 right after reset; drained lane0=3 (no residue from the aborted run); drop_err_o=0.
